// File: rtl/timer_sched_if.sv
// timer_sched_if: slave bus of the one-shot timer peripheral.
// master: the scheduler driving the strobes; slave: the timer answering with rdy_/irq.
interface timer_sched_if;
   logic        t_cs_;
   logic        t_as_;
   logic        t_rw;
   logic [1:0]  t_addr;
   logic [31:0] t_wr_data;
   logic        t_rdy_;
   logic        t_irq;

   modport master (
      output t_cs_, t_as_, t_rw, t_addr, t_wr_data,
      input  t_rdy_, t_irq
   );

   modport slave (
      input  t_cs_, t_as_, t_rw, t_addr, t_wr_data,
      output t_rdy_, t_irq
   );
endinterface

// File: rtl/timer_sched.sv
// timer_sched: shares one one-shot timer among REQ_NUM requesters.
// Arbitrates, programs EXPR/COUNTER/CTRL, waits for the irq, clears INTR, pulses done.
// Build option: TIMER_SCHED_FIXED_PRIO_EN selects fixed priority (lowest index wins)
// instead of the default round-robin arbitration.
module timer_sched #(
   parameter int unsigned REQ_NUM   = 4,
   parameter int unsigned REQ_IDX_W = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [REQ_NUM-1:0]     req,
   input  logic [32*REQ_NUM-1:0]  period,
   output logic [REQ_NUM-1:0]     done,
   output logic [REQ_IDX_W-1:0]   owner,
   output logic                   busy,
   timer_sched_if.master          tbus
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] WR_EXPR  = 3'd1;
   localparam logic [2:0] WR_CNT   = 3'd2;
   localparam logic [2:0] WR_CTRL  = 3'd3;
   localparam logic [2:0] WAIT_IRQ = 3'd4;
   localparam logic [2:0] CLR_INTR = 3'd5;
   localparam logic [2:0] ABORT    = 3'd6;
   localparam logic [2:0] DONE     = 3'd7;

   localparam logic [1:0] ADDR_CTRL = 2'd0;
   localparam logic [1:0] ADDR_INTR = 2'd1;
   localparam logic [1:0] ADDR_EXPR = 2'd2;
   localparam logic [1:0] ADDR_CNT  = 2'd3;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   logic [2:0]            state_q, state_d;
   logic [REQ_IDX_W-1:0]  owner_q, owner_d;
   logic [31:0]           expr_q, expr_d;
   logic                  busy_q, busy_d;
   logic [REQ_NUM-1:0]    done_q, done_d;
   logic                  aborted_q, aborted_d;
   logic                  cs_q, cs_d;
   logic                  as_q, as_d;
   logic                  rw_q, rw_d;
   logic [1:0]            addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
`ifndef TIMER_SCHED_FIXED_PRIO_EN
   logic [REQ_IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
`endif

   logic                  win_found;
   logic [REQ_IDX_W-1:0]  win_idx;
   logic [REQ_IDX_W-1:0]  cand;
   logic [31:0]           win_period;

   logic                  wr_active;
   logic [1:0]            wr_addr;
   logic [31:0]           wr_data;
   logic [2:0]            wr_next;

   // Pick the winning requester and fetch its period.
   always_comb begin
      win_found  = 1'b0;
      win_idx    = '0;
      cand       = '0;
      win_period = '0;
      for (int unsigned i = 0; i < REQ_NUM; i++) begin
`ifdef TIMER_SCHED_FIXED_PRIO_EN
         cand = REQ_IDX_W'(i);
`else
         cand = REQ_IDX_W'((32'(rr_ptr_q) + i) % REQ_NUM);
`endif
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
      for (int unsigned j = 0; j < REQ_NUM; j++) begin
         if (REQ_IDX_W'(j) == win_idx) win_period = period[32*j +: 32];
      end
   end

   // Session FSM plus the shared bus-write engine; write states only name addr/data/next.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      expr_d    = expr_q;
      busy_d    = busy_q;
      done_d    = '0;
      aborted_d = aborted_q;
      cs_d      = cs_q;
      as_d      = as_q;
      rw_d      = rw_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
`ifndef TIMER_SCHED_FIXED_PRIO_EN
      rr_ptr_d  = rr_ptr_q;
`endif
      wr_active = 1'b0;
      wr_addr   = ADDR_CTRL;
      wr_data   = '0;
      wr_next   = state_q;

      case (state_q)
         IDLE: begin
            if (win_found) begin
               owner_d   = win_idx;
               expr_d    = (win_period == '0) ? '0 : win_period - 32'd1;
               busy_d    = 1'b1;
               aborted_d = 1'b0;
               state_d   = WR_EXPR;
            end
         end
         WR_EXPR: begin
            wr_active = 1'b1;
            wr_addr   = ADDR_EXPR;
            wr_data   = expr_q;
            wr_next   = WR_CNT;
         end
         WR_CNT: begin
            wr_active = 1'b1;
            wr_addr   = ADDR_CNT;
            wr_data   = '0;
            wr_next   = WR_CTRL;
         end
         WR_CTRL: begin
            wr_active = 1'b1;
            wr_addr   = ADDR_CTRL;
            wr_data   = 32'h1;
            wr_next   = WAIT_IRQ;
         end
         WAIT_IRQ: begin
            if (tbus.t_irq) begin
               state_d = CLR_INTR;
            end else if (!req[owner_q]) begin
               aborted_d = 1'b1;
               state_d   = ABORT;
            end
         end
         ABORT: begin
            wr_active = 1'b1;
            wr_addr   = ADDR_CTRL;
            wr_data   = '0;
            wr_next   = CLR_INTR;
         end
         CLR_INTR: begin
            wr_active = 1'b1;
            wr_addr   = ADDR_INTR;
            wr_data   = '0;
            wr_next   = aborted_q ? IDLE : DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Launch cycle (strobes high) loads the strobe; the write is held until rdy_ is seen low.
      if (wr_active) begin
         if (!cs_q) begin
            if (!tbus.t_rdy_) begin
               cs_d    = 1'b1;
               as_d    = 1'b1;
               rw_d    = RW_READ;
               state_d = wr_next;
            end
         end else begin
            cs_d    = 1'b0;
            as_d    = 1'b0;
            rw_d    = RW_WRITE;
            addr_d  = wr_addr;
            wdata_d = wr_data;
         end
      end

      // Leaving CLR_INTR ends the session; only a non-aborted one pulses done.
      if (state_q == CLR_INTR && state_d != CLR_INTR) begin
         busy_d = 1'b0;
         if (!aborted_q) begin
            done_d[owner_q] = 1'b1;
`ifndef TIMER_SCHED_FIXED_PRIO_EN
            rr_ptr_d = (owner_q == REQ_IDX_W'(REQ_NUM - 1)) ? '0 : owner_q + 1'b1;
`endif
         end
      end
   end

   // State and registered bus outputs, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         expr_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= '0;
         aborted_q <= 1'b0;
         cs_q      <= 1'b1;
         as_q      <= 1'b1;
         rw_q      <= RW_READ;
         addr_q    <= '0;
         wdata_q   <= '0;
`ifndef TIMER_SCHED_FIXED_PRIO_EN
         rr_ptr_q  <= '0;
`endif
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         expr_q    <= expr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         cs_q      <= cs_d;
         as_q      <= as_d;
         rw_q      <= rw_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
`ifndef TIMER_SCHED_FIXED_PRIO_EN
         rr_ptr_q  <= rr_ptr_d;
`endif
      end
   end

   assign tbus.t_cs_     = cs_q;
   assign tbus.t_as_     = as_q;
   assign tbus.t_rw      = rw_q;
   assign tbus.t_addr    = addr_q;
   assign tbus.t_wr_data = wdata_q;
   assign done           = done_q;
   assign owner          = owner_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_timer_sched.sv
// tb_timer_sched: directed bench for timer_sched with a small one-shot timer model.
`timescale 1ns/1ps
module tb_timer_sched;
   localparam int unsigned N = 4;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    req = '0;
   logic [32*N-1:0] period = '0;
   logic [N-1:0]    done;
   logic [1:0]      owner;
   logic            busy;

   timer_sched_if tif();

   timer_sched #(.REQ_NUM(4), .REQ_IDX_W(2)) dut (
      .clk    (clk),
      .reset  (reset),
      .req    (req),
      .period (period),
      .done   (done),
      .owner  (owner),
      .busy   (busy),
      .tbus   (tif.master)
   );

   always #5 clk = ~clk;

   // Timer model: registered rdy_, one-shot counter, write log of first strobe cycles.
   logic        strobe;
   logic [31:0] m_expr, m_cnt;
   logic        m_run;
   logic [33:0] wlog[$];
   assign strobe = !tif.t_cs_ && !tif.t_as_;

   always @(posedge clk) begin
      if (reset) begin
         tif.t_rdy_ <= 1'b1;
         tif.t_irq  <= 1'b0;
         m_run      <= 1'b0;
         m_cnt      <= '0;
         m_expr     <= '0;
      end else begin
         tif.t_rdy_ <= !strobe;
         if (m_run) begin
            if (m_cnt >= m_expr) begin
               tif.t_irq <= 1'b1;
               m_run     <= 1'b0;
            end else begin
               m_cnt <= m_cnt + 1;
            end
         end
         if (strobe && !tif.t_rw) begin
            if (tif.t_rdy_) wlog.push_back({tif.t_addr, tif.t_wr_data});
            case (tif.t_addr)
               2'd0: m_run  <= tif.t_wr_data[0];
               2'd1: tif.t_irq <= 1'b0;
               2'd2: m_expr <= tif.t_wr_data;
               default: m_cnt <= tif.t_wr_data;
            endcase
         end
      end
   end

   // Done-pulse and grant monitors.
   logic [N-1:0] done_prev = '0;
   logic         busy_prev = 1'b0;
   int unsigned  pulse_err = 0;
   int unsigned  done_cnt  = 0;
   logic [1:0]   grant_q[$];
   always @(negedge clk) begin
      if (done != '0 && done_prev != '0) pulse_err++;
      if (done != '0) done_cnt++;
      if (busy && !busy_prev) grant_q.push_back(owner);
      done_prev = done;
      busy_prev = busy;
   end

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      repeat (3) tick();
      reset = 1'b0;
      wlog.delete();
   endtask

   task automatic wait_done(input string tag, input int unsigned budget);
      int unsigned n = 0;
      while (done == '0 && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_done_seen"}, 32'(done != '0), 32'd1);
   endtask

   task automatic wait_log(input string tag, input int unsigned cnt, input int unsigned budget);
      int unsigned n = 0;
      while (wlog.size() < cnt && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_log_reached"}, 32'(wlog.size() >= cnt), 32'd1);
   endtask

   task automatic check_wr(input string tag, input int unsigned idx,
                           input logic [1:0] a, input logic [31:0] d);
      logic [33:0] e;
      check({tag, "_present"}, 32'(idx < wlog.size()), 32'd1);
      if (idx < wlog.size()) begin
         e = wlog[idx];
         check({tag, "_addr"}, 32'(e[33:32]), 32'(a));
         check({tag, "_data"}, e[31:0], d);
      end
   endtask

   initial begin
      logic [1:0] exp_own [5];
      int unsigned snap;
      int unsigned n;

      // Reset values
      do_reset();
      check("rst_cs", 32'(tif.t_cs_), 32'd1);
      check("rst_as", 32'(tif.t_as_), 32'd1);
      check("rst_rw", 32'(tif.t_rw), 32'd1);
      check("rst_addr", 32'(tif.t_addr), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_owner", 32'(owner), 32'd0);

      // Single request, period 10
      period[32*1 +: 32] = 32'd10;
      req = 4'b0010;
      wait_done("s1", 300);
      check("s1_done", 32'(done), 32'h2);
      check("s1_owner", 32'(owner), 32'd1);
      check("s1_busy", 32'(busy), 32'd0);
      check_wr("s1_expr", 0, 2'd2, 32'd9);
      check_wr("s1_cnt", 1, 2'd3, 32'd0);
      check_wr("s1_ctrl", 2, 2'd0, 32'd1);
      check_wr("s1_intr", 3, 2'd1, 32'd0);
      check("s1_nwr", 32'(wlog.size()), 32'd4);
      req = '0;
      tick();
      check("s1_done_low", 32'(done), 32'd0);
      repeat (3) tick();
      check("s1_idle_busy", 32'(busy), 32'd0);

      // All requesting, period 3
      do_reset();
`ifdef TIMER_SCHED_FIXED_PRIO_EN
      exp_own = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
      exp_own = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
      for (int unsigned i = 0; i < N; i++) period[32*i +: 32] = 32'd3;
      grant_q.delete();
      req = 4'b1111;
      for (int unsigned k = 0; k < 5; k++) begin
         wait_done($sformatf("s2_%0d", k), 300);
         check($sformatf("s2_done_%0d", k), 32'(done), 32'(4'b0001 << exp_own[k]));
         check($sformatf("s2_owner_%0d", k), 32'(owner), 32'(exp_own[k]));
         if (k == 4) req = '0;
         tick();
      end
      repeat (5) tick();
      check("s2_ngrants", 32'(grant_q.size()), 32'd5);
      for (int unsigned k = 0; k < 5; k++) begin
         if (k < grant_q.size()) check($sformatf("s2_grant_%0d", k), 32'(grant_q[k]), 32'(exp_own[k]));
      end
      check("s2_single_pulse", pulse_err, 32'd0);

      // Withdrawal in WAIT_IRQ
      do_reset();
      period[32*2 +: 32] = 32'd1000;
      req = 4'b0100;
      wait_log("s3", 3, 100);
      check_wr("s3_ctrl", 2, 2'd0, 32'd1);
      repeat (3) tick();
      snap = done_cnt;
      req = '0;
      n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      check("s3_busy", 32'(busy), 32'd0);
      check_wr("s3_stop", 3, 2'd0, 32'd0);
      check_wr("s3_clr", 4, 2'd1, 32'd0);
      check("s3_nwr", 32'(wlog.size()), 32'd5);
      check("s3_no_done", done_cnt - snap, 32'd0);
      period[32*0 +: 32] = 32'd4;
      req = 4'b0001;
      wait_done("s3_next", 300);
      check("s3_next_done", 32'(done), 32'h1);
      req = '0;
      tick();

      // Zero period
      do_reset();
      period[32*0 +: 32] = 32'd0;
      req = 4'b0001;
      wait_done("s4", 300);
      check("s4_done", 32'(done), 32'h1);
      check_wr("s4_expr", 0, 2'd2, 32'd0);
      check_wr("s4_ctrl", 2, 2'd0, 32'd1);
      req = '0;
      tick();

      // Reset during WR_CNT
      do_reset();
      period[32*3 +: 32] = 32'd5;
      req = 4'b1000;
      wait_log("s5", 2, 100);
      check("s5_cnt_strobe", 32'(tif.t_cs_), 32'd0);
      reset = 1'b1;
      tick();
      check("s5_cs", 32'(tif.t_cs_), 32'd1);
      check("s5_as", 32'(tif.t_as_), 32'd1);
      check("s5_busy", 32'(busy), 32'd0);
      check("s5_owner", 32'(owner), 32'd0);
      reset = 1'b0;
      req = '0;
      repeat (4) tick();
      check("s5_idle_busy", 32'(busy), 32'd0);
      check("s5_idle_cs", 32'(tif.t_cs_), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
